alu_iter: RTL and testbench
===========================

# alu_iter

Parametrised execute-stage ALU that generalises the single-cycle add/sub/or/pass unit. It has a WIDTH-bit datapath, a 4-bit binary opcode, and a registered result behind a valid/ready handshake. It adds iterative multiply and unsigned divide, which hold the unit busy for WIDTH cycles. It sits between the issue stage and the writeback mux and accepts one operation at a time.

## Interface
- WIDTH, 32: datapath width; power of two, ≥ 8.
- SHW, $clog2(WIDTH): shift-amount width (local, derived).
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  pipeline flush; abandons any in-flight operation.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit can accept an operation this cycle.
- in_op  input  4  opcode (see Operation).
- in_src1  input  WIDTH  operand 1.
- in_src2  input  WIDTH  operand 2.
- out_valid  output  1  out_result holds a finished result.
- out_ready  input  1  consumer takes the result this cycle.
- out_result  output  WIDTH  registered result.

## Operation
- Opcodes:
  - 0 add, 1 sub (src1 + ~src2 + 1), 2 or, 3 and, 4 xor.
  - 5 slt (signed, result 0/1), 6 sltu (unsigned, result 0/1).
  - 7 sll, 8 srl, 9 sra; the shift amount is src2[SHW-1:0].
  - 10 pass src1.
  - 11 mul (low WIDTH bits of the product), 12 mulh (high WIDTH bits, signed×signed), 13 mulhu (high WIDTH bits, unsigned).
  - 14 divu (quotient), 15 modu (remainder).
- All arithmetic is modulo 2^WIDTH. There are no overflow flags; carries are dropped.
- State machine IDLE / BUSY / DONE:
  - IDLE: in_ready=1. On accept (in_valid & in_ready & ~flush):
    - Ops 0–10 and div-by-zero: out_result is computed combinationally and registered; go to DONE.
    - Ops 11–13: latch operands; go to BUSY with counter=0.
    - Ops 14–15 with src2≠0: latch operands; go to BUSY with counter=0.
  - BUSY: one radix-2 step per cycle.
    - Multiply: shift-add on a 2·WIDTH accumulator. mulh converts operands to magnitudes, records the sign, and negates the 2·WIDTH product at completion.
    - Divide: restoring shift-subtract.
    - After step WIDTH-1 (counter==WIDTH-1), write out_result and go to DONE. in_ready=0.
  - DONE: out_valid=1.
    - out_ready=1 with no new accept: go to IDLE.
    - out_ready=1 with a simultaneous new accept: behave as an accept from IDLE; out_valid stays 1 only if the new op is single-cycle.
    - out_ready=0: hold out_result and out_valid stable; in_ready=0.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This gives back-to-back single-cycle ops at full throughput.
- Divide by zero: divu returns all ones; modu returns src1. Both complete in 1 cycle (no BUSY).
- Flush: highest priority. Next state is IDLE, out_valid=0 next cycle, counter cleared. An input offered in the same cycle is dropped. out_result content is don't-care after flush.
- Undefined behaviour: none. All 16 opcodes are defined.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, out_valid=0, out_result=0, counter=0, internal operand/accumulator registers=0. Reset mid-BUSY discards the operation and produces no out_valid.
- in_ready after reset is 1 in the first cycle with rst_n=1.
- Single-cycle ops and div-by-zero: accepted in cycle N, out_valid=1 in cycle N+1.
- Multiply/divide: accepted in cycle N, BUSY for cycles N+1..N+WIDTH, out_valid=1 in cycle N+WIDTH+1. This is 33 cycles for WIDTH=32.
- The result is held indefinitely under out_ready=0. There is no timeout.
- in_ready is combinational from state and out_ready only, never from in_valid.
- out_result and out_valid are register outputs with no combinational path from inputs.

## Test plan
- Basic ALU, WIDTH=32:
  - add 0xFFFFFFFF+1 → 0x00000000.
  - sub 5−7 → 0xFFFFFFFE.
  - slt 0x80000000,1 → 1; sltu 0x80000000,1 → 0.
  - sra 0x80000000 by 0x24 (amount 4) → 0xF8000000.
  - Issue back-to-back with out_ready held 1: 1 result per cycle, in order.
- Multiply, src1=src2=0xFFFFFFFF:
  - mul → 0x00000001; mulh → 0x00000000; mulhu → 0xFFFFFFFE.
  - out_valid exactly 33 cycles after accept; in_ready=0 throughout BUSY.
- Divide:
  - divu 100/7 → 14 and modu 100/7 → 2, each in 33 cycles.
  - divu 0x1234/0 → 0xFFFFFFFF and modu 0x1234/0 → 0x1234, each with out_valid the next cycle.
- Backpressure: out_ready=0 for 5 cycles after a result appears. out_result is stable, in_ready=0, and an in_valid pulse is not accepted. Raising out_ready together with in_valid accepts the new op in that cycle.
- Flush: assert flush at BUSY cycle 10 of a divu, with in_valid=1 in the same cycle. out_valid never rises for either op, in_ready=1 next cycle, and a following add 2+3 → 5 with normal latency.
- Reset and parameter sweep:
  - rst_n=0 mid-multiply → out_valid=0, state IDLE, out_result=0.
  - Rerun the mul, divu and shift checks at WIDTH=8, e.g. divu 0xFF/0x10 → 0x0F in 9 cycles and sll by 0x0B (amount 3).

Source files
------------

// File: rtl/alu_iter_if.sv
// Issue/writeback handshake bundle for alu_iter: operation request, result return and flush.
interface alu_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_src1;
  logic [WIDTH-1:0] in_src2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;

  modport master (
    output flush, in_valid, in_op, in_src1, in_src2, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  flush, in_valid, in_op, in_src1, in_src2, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus WIDTH-cycle radix-2 multiply and
// unsigned restoring divide, with a registered result behind a valid/ready handshake.
module alu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_iter_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               r_state, w_state_nxt;
  logic [SHW-1:0]       r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]     r_result, w_result_nxt;
  logic [WIDTH-1:0]     r_opb, w_opb_nxt;
  logic [2*WIDTH-1:0]   r_acc, w_acc_nxt;
  logic [3:0]           r_op, w_op_nxt;
  logic                 r_neg, w_neg_nxt;

  logic                 w_accept, w_single, w_is_mulh, w_is_div;
  logic [SHW-1:0]       w_shamt;
  logic [WIDTH-1:0]     w_alu, w_mag1, w_mag2, w_final;
  logic [WIDTH:0]       w_mul_sum, w_rsh, w_diff;
  logic                 w_borrow;
  logic [2*WIDTH-1:0]   w_mul_step, w_div_step, w_step, w_prod_s;

  assign bus.in_ready   = (r_state == StIdle) | ((r_state == StDone) & bus.out_ready);
  assign bus.out_valid  = (r_state == StDone);
  assign bus.out_result = r_result;

  assign w_accept  = bus.in_valid & bus.in_ready & ~bus.flush;
  assign w_shamt   = bus.in_src2[SHW-1:0];
  assign w_is_mulh = (bus.in_op == 4'd12);
  assign w_is_div  = (bus.in_op[3:1] == 3'b111);
  // Divide by zero resolves in the single-cycle path.
  assign w_single  = (bus.in_op < 4'd11) | (w_is_div & (bus.in_src2 == '0));
  assign w_mag1    = (w_is_mulh & bus.in_src1[WIDTH-1]) ? -bus.in_src1 : bus.in_src1;
  assign w_mag2    = (w_is_mulh & bus.in_src2[WIDTH-1]) ? -bus.in_src2 : bus.in_src2;

  always_comb begin
    w_alu = '0;
    case (bus.in_op)
      4'd0:  w_alu = bus.in_src1 + bus.in_src2;
      4'd1:  w_alu = bus.in_src1 + ~bus.in_src2 + WIDTH'(1);
      4'd2:  w_alu = bus.in_src1 | bus.in_src2;
      4'd3:  w_alu = bus.in_src1 & bus.in_src2;
      4'd4:  w_alu = bus.in_src1 ^ bus.in_src2;
      4'd5:  w_alu = WIDTH'($signed(bus.in_src1) < $signed(bus.in_src2));
      4'd6:  w_alu = WIDTH'(bus.in_src1 < bus.in_src2);
      4'd7:  w_alu = bus.in_src1 << w_shamt;
      4'd8:  w_alu = bus.in_src1 >> w_shamt;
      4'd9:  w_alu = $unsigned($signed(bus.in_src1) >>> w_shamt);
      4'd10: w_alu = bus.in_src1;
      4'd14: w_alu = '1;
      4'd15: w_alu = bus.in_src1;
      default: w_alu = '0;
    endcase
  end

  // Multiply: r_acc = {partial product, multiplier}; divide: r_acc = {remainder, quotient}.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_rsh      = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rsh - {1'b0, r_opb};
  assign w_borrow   = w_diff[WIDTH];
  assign w_div_step = {(w_borrow ? w_rsh[WIDTH-1:0] : w_diff[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], ~w_borrow};
  assign w_step     = (r_op[3:1] == 3'b111) ? w_div_step : w_mul_step;
  assign w_prod_s   = r_neg ? -w_step : w_step;

  always_comb begin
    w_final = w_step[WIDTH-1:0];
    case (r_op)
      4'd12:   w_final = w_prod_s[2*WIDTH-1:WIDTH];
      4'd13:   w_final = w_step[2*WIDTH-1:WIDTH];
      4'd15:   w_final = w_step[2*WIDTH-1:WIDTH];
      default: w_final = w_step[WIDTH-1:0];
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_opb_nxt    = r_opb;
    w_acc_nxt    = r_acc;
    w_op_nxt     = r_op;
    w_neg_nxt    = r_neg;
    if (bus.flush) begin
      w_state_nxt = StIdle;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (w_accept) begin
            if (w_single) begin
              w_result_nxt = w_alu;
              w_state_nxt  = StDone;
            end else begin
              w_op_nxt    = bus.in_op;
              w_acc_nxt   = w_is_div ? {{WIDTH{1'b0}}, bus.in_src1} : {{WIDTH{1'b0}}, w_mag2};
              w_opb_nxt   = w_is_div ? bus.in_src2 : w_mag1;
              w_neg_nxt   = w_is_mulh & (bus.in_src1[WIDTH-1] ^ bus.in_src2[WIDTH-1]);
              w_cnt_nxt   = '0;
              w_state_nxt = StBusy;
            end
          end else if ((r_state == StDone) && bus.out_ready) begin
            w_state_nxt = StIdle;
          end
        end
        StBusy: begin
          w_acc_nxt = w_step;
          w_cnt_nxt = r_cnt + SHW'(1);
          if (r_cnt == SHW'(WIDTH - 1)) begin
            w_result_nxt = w_final;
            w_cnt_nxt    = '0;
            w_state_nxt  = StDone;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_result <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_opb    <= w_opb_nxt;
      r_acc    <= w_acc_nxt;
      r_op     <= w_op_nxt;
      r_neg    <= w_neg_nxt;
    end
  end
endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter at WIDTH=32 and WIDTH=8: vector tables plus handshake,
// backpressure, flush and reset sequences.
module tb_alu_iter;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  alu_iter_if #(.WIDTH(32)) bus32 ();
  alu_iter_if #(.WIDTH(8))  bus8 ();

  alu_iter #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  alu_iter #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      bus8.in_valid = v; bus8.in_op = op; bus8.in_src1 = a[7:0]; bus8.in_src2 = b[7:0];
    end else begin
      bus32.in_valid = v; bus32.in_op = op; bus32.in_src1 = a; bus32.in_src2 = b;
    end
  endtask

  task automatic sample(input bit w8, output logic ov, output logic ir, output logic [31:0] res);
    if (w8) begin
      ov = bus8.out_valid; ir = bus8.in_ready; res = {24'h0, bus8.out_result};
    end else begin
      ov = bus32.out_valid; ir = bus32.in_ready; res = bus32.out_result;
    end
  endtask

  task automatic run_vec(input bit w8, input string name, input vec_t v);
    logic ov, ir;
    logic [31:0] res;
    int lat;
    @(negedge clk);
    if (w8) bus8.out_ready = 1'b1; else bus32.out_ready = 1'b1;
    drive(w8, 1'b1, v.op, v.a, v.b);
    #1 sample(w8, ov, ir, res);
    check({name, " in_ready"}, 32'(ir), 32'd1);
    @(negedge clk);
    drive(w8, 1'b0, 4'd0, 32'd0, 32'd0);
    lat = 1;
    sample(w8, ov, ir, res);
    while (!ov && lat < 100) begin
      check({name, " busy in_ready"}, 32'(ir), 32'd0);
      @(negedge clk);
      lat++;
      sample(w8, ov, ir, res);
    end
    check({name, " latency"}, 32'(lat), 32'(v.lat));
    check({name, " result"}, res, v.exp);
  endtask

  vec_t vt32 [25];
  vec_t vt8  [10];

  initial begin
    logic ov, ir, seen;
    logic [31:0] res;
    logic [31:0] b2b_exp [4];

    vt32[0]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
    vt32[1]  = '{4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1};
    vt32[2]  = '{4'd2,  32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1};
    vt32[3]  = '{4'd3,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1};
    vt32[4]  = '{4'd4,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1};
    vt32[5]  = '{4'd5,  32'h80000000, 32'h00000001, 32'h00000001, 1};
    vt32[6]  = '{4'd6,  32'h80000000, 32'h00000001, 32'h00000000, 1};
    vt32[7]  = '{4'd5,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1};
    vt32[8]  = '{4'd7,  32'h00000001, 32'h00000024, 32'h00000010, 1};
    vt32[9]  = '{4'd8,  32'h80000000, 32'h00000024, 32'h08000000, 1};
    vt32[10] = '{4'd9,  32'h80000000, 32'h00000024, 32'hF8000000, 1};
    vt32[11] = '{4'd10, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 1};
    vt32[12] = '{4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33};
    vt32[13] = '{4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    vt32[14] = '{4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vt32[15] = '{4'd12, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 33};
    vt32[16] = '{4'd11, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 33};
    vt32[17] = '{4'd12, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vt32[18] = '{4'd13, 32'h80000000, 32'h00000004, 32'h00000002, 33};
    vt32[19] = '{4'd14, 32'd100,      32'd7,        32'd14,       33};
    vt32[20] = '{4'd15, 32'd100,      32'd7,        32'd2,        33};
    vt32[21] = '{4'd14, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1};
    vt32[22] = '{4'd15, 32'h00001234, 32'h00000000, 32'h00001234, 1};
    vt32[23] = '{4'd15, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 33};
    vt32[24] = '{4'd14, 32'h00000005, 32'h00000007, 32'h00000000, 33};

    vt8[0] = '{4'd11, 32'hFF, 32'hFF, 32'h01, 9};
    vt8[1] = '{4'd12, 32'hFF, 32'hFF, 32'h00, 9};
    vt8[2] = '{4'd13, 32'hFF, 32'hFF, 32'hFE, 9};
    vt8[3] = '{4'd14, 32'hFF, 32'h10, 32'h0F, 9};
    vt8[4] = '{4'd15, 32'hFF, 32'h10, 32'h0F, 9};
    vt8[5] = '{4'd7,  32'h01, 32'h0B, 32'h08, 1};
    vt8[6] = '{4'd9,  32'h80, 32'h0C, 32'hF8, 1};
    vt8[7] = '{4'd12, 32'hFD, 32'h05, 32'hFF, 9};
    vt8[8] = '{4'd14, 32'h12, 32'h00, 32'hFF, 1};
    vt8[9] = '{4'd15, 32'h12, 32'h00, 32'h12, 1};

    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus32.flush = 1'b0; bus32.out_ready = 1'b1;
    bus8.flush = 1'b0;  bus8.out_ready = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int w = 0; w < 2; w++) begin
      sample(w[0], ov, ir, res);
      check($sformatf("reset out_valid w%0d", w), 32'(ov), 32'd0);
      check($sformatf("reset out_result w%0d", w), res, 32'd0);
      check($sformatf("reset in_ready w%0d", w), 32'(ir), 32'd1);
    end

    for (int i = 0; i < 25; i++) run_vec(1'b0, $sformatf("w32 v%0d", i), vt32[i]);
    for (int i = 0; i < 10; i++) run_vec(1'b1, $sformatf("w8 v%0d", i), vt8[i]);

    // Back-to-back single-cycle ops at full throughput.
    b2b_exp = '{32'd3, 32'd7, 32'd5, 32'd9};
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        sample(1'b0, ov, ir, res);
        check($sformatf("b2b%0d valid", i), 32'(ov), 32'd1);
        check($sformatf("b2b%0d result", i), res, b2b_exp[i-1]);
      end
      case (i)
        0: drive(1'b0, 1'b1, 4'd0, 32'd1, 32'd2);
        1: drive(1'b0, 1'b1, 4'd1, 32'd10, 32'd3);
        2: drive(1'b0, 1'b1, 4'd4, 32'd6, 32'd3);
        3: drive(1'b0, 1'b1, 4'd10, 32'd9, 32'd0);
        default: drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      endcase
      if (i < 4) begin
        #1 sample(1'b0, ov, ir, res);
        check($sformatf("b2b%0d in_ready", i), 32'(ir), 32'd1);
      end
      @(negedge clk);
    end

    // Backpressure: result held for 5 cycles, offered op refused, then release + accept.
    bus32.out_ready = 1'b0;
    drive(1'b0, 1'b1, 4'd0, 32'd2, 32'd3);
    @(negedge clk);
    sample(1'b0, ov, ir, res);
    check("bp first valid", 32'(ov), 32'd1);
    check("bp first result", res, 32'd5);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 4'd10, 32'h777, 32'd0);
      #1 sample(1'b0, ov, ir, res);
      check($sformatf("bp%0d in_ready", i), 32'(ir), 32'd0);
      @(negedge clk);
      sample(1'b0, ov, ir, res);
      check($sformatf("bp%0d valid", i), 32'(ov), 32'd1);
      check($sformatf("bp%0d result", i), res, 32'd5);
    end
    drive(1'b0, 1'b1, 4'd2, 32'h30, 32'h0C);
    bus32.out_ready = 1'b1;
    #1 sample(1'b0, ov, ir, res);
    check("bp release in_ready", 32'(ir), 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    sample(1'b0, ov, ir, res);
    check("bp new valid", 32'(ov), 32'd1);
    check("bp new result", res, 32'h3C);
    @(negedge clk);
    sample(1'b0, ov, ir, res);
    check("bp drained valid", 32'(ov), 32'd0);

    // Flush at BUSY cycle 10 of a divu, with a new op offered in the same cycle.
    drive(1'b0, 1'b1, 4'd14, 32'd1000, 32'd3);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    bus32.flush = 1'b1;
    drive(1'b0, 1'b1, 4'd0, 32'd7, 32'd7);
    @(negedge clk);
    bus32.flush = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    sample(1'b0, ov, ir, res);
    check("flush valid", 32'(ov), 32'd0);
    check("flush in_ready", 32'(ir), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      sample(1'b0, ov, ir, res);
      seen = seen | ov;
    end
    check("flush no valid", 32'(seen), 32'd0);
    run_vec(1'b0, "post-flush add", '{4'd0, 32'd2, 32'd3, 32'd5, 1});

    // Reset in the middle of a multiply.
    @(negedge clk);
    drive(1'b0, 1'b1, 4'd11, 32'd1234, 32'd5678);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sample(1'b0, ov, ir, res);
    check("midrst valid", 32'(ov), 32'd0);
    check("midrst result", res, 32'd0);
    check("midrst in_ready", 32'(ir), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      sample(1'b0, ov, ir, res);
      seen = seen | ov;
    end
    check("midrst no valid", 32'(seen), 32'd0);
    run_vec(1'b0, "post-reset mul", '{4'd11, 32'd1234, 32'd5678, 32'd7006652, 33});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
